// File: rtl/fetch_mem_arbiter.sv
// Arbiter sharing one single-port fixed-latency RAM between the fetch stage and the
// memory stage; produces per-requester valid pulses and stalls, and drops flushed fetches.
module fetch_mem_arbiter #(
    parameter int WORD_LEN = 32,
    parameter int MEM_LAT  = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                if_req,
    input  logic [WORD_LEN-1:0] if_addr,
    output logic [WORD_LEN-1:0] if_rdata,
    output logic                if_valid,
    output logic                if_stall,
    input  logic                flush,
    input  logic                mem_rd_req,
    input  logic                mem_wr_req,
    input  logic [WORD_LEN-1:0] mem_addr,
    input  logic [WORD_LEN-1:0] mem_wdata,
    output logic [WORD_LEN-1:0] mem_rdata,
    output logic                mem_valid,
    output logic                mem_stall,
    output logic                ram_en,
    output logic                ram_we,
    output logic [WORD_LEN-1:0] ram_addr,
    output logic [WORD_LEN-1:0] ram_wdata,
    input  logic [WORD_LEN-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} ownerT;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    stateT               state;
    stateT               stateNext;
    ownerT               owner;
    logic [3:0]          waitCnt;
    logic                ifOwed;
    logic                killed;
    logic [WORD_LEN-1:0] addrReg;
    logic [WORD_LEN-1:0] wdataReg;
    logic                weReg;
    logic [WORD_LEN-1:0] ifRdataReg;
    logic [WORD_LEN-1:0] memRdataReg;

    logic memReq;
    logic grantIf;
    logic grantMem;
    logic killNow;

    assign memReq   = mem_rd_req | mem_wr_req;
    // Memory stage normally wins; a fetch that already lost once gets the next slot.
    assign grantIf  = if_req & (~memReq | ifOwed);
    assign grantMem = memReq & ~grantIf;
    // A flush in the current cycle must already suppress capture and the valid pulse.
    assign killNow  = killed | (flush & (owner == OWN_IF) & (state != IDLE));

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (if_req | memReq) stateNext = ISSUE;
            ISSUE:   stateNext = WAIT;
            WAIT:    if (waitCnt == 4'd0) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            waitCnt     <= 4'd0;
            ifOwed      <= 1'b0;
            killed      <= 1'b0;
            addrReg     <= '0;
            wdataReg    <= '0;
            weReg       <= 1'b0;
            ifRdataReg  <= '0;
            memRdataReg <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (grantIf) begin
                        owner   <= OWN_IF;
                        addrReg <= if_addr;
                        weReg   <= 1'b0;
                        ifOwed  <= 1'b0;
                    end else if (grantMem) begin
                        owner    <= OWN_MEM;
                        addrReg  <= mem_addr;
                        wdataReg <= mem_wdata;
                        weReg    <= mem_wr_req;
                        ifOwed   <= if_req;
                    end
                end
                ISSUE: waitCnt <= CNT_LOAD;
                WAIT: begin
                    if (waitCnt == 4'd0) begin
                        if (owner == OWN_IF && !killNow) ifRdataReg <= ram_rdata;
                        if (owner == OWN_MEM && !weReg)  memRdataReg <= ram_rdata;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                RESP: owner <= OWN_NONE;
                default: owner <= OWN_NONE;
            endcase

            if (state == RESP) killed <= 1'b0;
            else if (killNow)  killed <= 1'b1;
        end
    end

    assign ram_en    = (state == ISSUE);
    assign ram_we    = weReg;
    assign ram_addr  = addrReg;
    assign ram_wdata = wdataReg;

    assign if_rdata  = ifRdataReg;
    assign mem_rdata = memRdataReg;
    assign if_valid  = (state == RESP) & (owner == OWN_IF) & ~killNow;
    assign mem_valid = (state == RESP) & (owner == OWN_MEM);
    assign if_stall  = if_req & ~if_valid;
    assign mem_stall = memReq & ~mem_valid;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: RAM model with fixed latency, scoreboard queues
// for returned data, and cycle-exact checks of grants, valids and stalls.
module tb_fetch_mem_arbiter;

    localparam int WL  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          if_req;
    logic [WL-1:0] if_addr;
    logic [WL-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;
    logic          flush;
    logic          mem_rd_req;
    logic          mem_wr_req;
    logic [WL-1:0] mem_addr;
    logic [WL-1:0] mem_wdata;
    logic [WL-1:0] mem_rdata;
    logic          mem_valid;
    logic          mem_stall;
    logic          ram_en;
    logic          ram_we;
    logic [WL-1:0] ram_addr;
    logic [WL-1:0] ram_wdata;
    logic [WL-1:0] ram_rdata;

    always #5 clk = ~clk;

    fetch_mem_arbiter #(.WORD_LEN(WL), .MEM_LAT(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall), .flush(flush),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .mem_stall(mem_stall), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // RAM model: fixed contents plus one writable location, LAT-cycle read pipeline.
    logic          wrHas;
    logic [WL-1:0] wrAddr;
    logic [WL-1:0] wrData;
    logic [WL-1:0] pipe [LAT];

    function automatic logic [WL-1:0] ramVal(input logic [WL-1:0] a);
        if (wrHas && wrAddr == a) return wrData;
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h14:  return 32'h11112222;
            32'h20:  return 32'h77778888;
            32'h30:  return 32'h55556666;
            32'h40:  return 32'hCAFEF00D;
            default: return ~a;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rstn) wrHas <= 1'b0;
        else if (ram_en && ram_we) begin
            wrHas  <= 1'b1;
            wrAddr <= ram_addr;
            wrData <= ram_wdata;
        end
        pipe[0] <= (ram_en && !ram_we) ? ramVal(ram_addr) : 32'hBAD0BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata = pipe[LAT-1];

    int            checks   = 0;
    int            failures = 0;
    logic [WL-1:0] ifQ[$];
    logic [WL-1:0] memQ[$];
    logic [WL-1:0] grantLog[$];
    logic [WL-1:0] expMemRdata;

    task automatic chk(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [WL-1:0] e;
        @(posedge clk);
        #1;
        if (ram_en) grantLog.push_back(ram_addr);
        if (if_valid) begin
            chk("if_q_nonempty", 32'(ifQ.size() > 0), 32'd1);
            if (ifQ.size() > 0) begin
                e = ifQ.pop_front();
                chk("sb_if_rdata", if_rdata, e);
            end
        end
        if (mem_valid) begin
            chk("mem_q_nonempty", 32'(memQ.size() > 0), 32'd1);
            if (memQ.size() > 0) begin
                e = memQ.pop_front();
                chk("sb_mem_rdata", mem_rdata, e);
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_if_rdata"},  if_rdata,  '0);
        chk({tag, "_if_valid"},  {31'd0, if_valid},  '0);
        chk({tag, "_if_stall"},  {31'd0, if_stall},  '0);
        chk({tag, "_mem_rdata"}, mem_rdata, '0);
        chk({tag, "_mem_valid"}, {31'd0, mem_valid}, '0);
        chk({tag, "_mem_stall"}, {31'd0, mem_stall}, '0);
        chk({tag, "_ram_en"},    {31'd0, ram_en},    '0);
        chk({tag, "_ram_we"},    {31'd0, ram_we},    '0);
        chk({tag, "_ram_addr"},  ram_addr,  '0);
        chk({tag, "_ram_wdata"}, ram_wdata, '0);
    endtask

    initial begin
        int nMem;
        int nIf;
        int lat;
        rstn = 1'b0; if_req = 1'b0; if_addr = '0; flush = 1'b0;
        mem_rd_req = 1'b0; mem_wr_req = 1'b0; mem_addr = '0; mem_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("rst");
        rstn = 1'b1;
        step();

        // Single fetch
        if_addr = 32'h10; if_req = 1'b1; ifQ.push_back(32'hDEADBEEF);
        #1 chk("t1_stall_c0", {31'd0, if_stall}, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("t1_ram_en_c%0d", c), {31'd0, ram_en}, 32'(c == 1));
            if (c == 1) chk("t1_ram_addr", ram_addr, 32'h10);
            chk($sformatf("t1_if_valid_c%0d", c), {31'd0, if_valid}, 32'(c == 4));
            chk($sformatf("t1_if_stall_c%0d", c), {31'd0, if_stall}, 32'(c < 4));
        end
        chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        step();

        // Simultaneous requests: MEM first, then IF
        if_addr = 32'h14; mem_addr = 32'h40; if_req = 1'b1; mem_rd_req = 1'b1;
        memQ.push_back(32'hCAFEF00D); ifQ.push_back(32'h11112222);
        expMemRdata = 32'hCAFEF00D;
        for (int c = 1; c <= 9; c++) begin
            step();
            chk($sformatf("t2_mem_valid_c%0d", c), {31'd0, mem_valid}, 32'(c == 4));
            chk($sformatf("t2_if_valid_c%0d", c), {31'd0, if_valid}, 32'(c == 9));
            if (c == 1) chk("t2_grant1_addr", ram_addr, 32'h40);
            if (c == 6) begin
                chk("t2_grant2_en", {31'd0, ram_en}, 32'd1);
                chk("t2_grant2_addr", ram_addr, 32'h14);
            end
            if (c == 4) mem_rd_req = 1'b0;
            if (c == 9) if_req = 1'b0;
        end
        step();

        // Fairness: both held, grants must alternate
        grantLog.delete();
        if_req = 1'b1; mem_rd_req = 1'b1;
        memQ.push_back(32'hCAFEF00D); memQ.push_back(32'hCAFEF00D);
        ifQ.push_back(32'h11112222);  ifQ.push_back(32'h11112222);
        nMem = 0; nIf = 0;
        for (int c = 0; c < 40 && (nMem < 2 || nIf < 2); c++) begin
            step();
            if (mem_valid) begin nMem++; if (nMem == 2) mem_rd_req = 1'b0; end
            if (if_valid)  begin nIf++;  if (nIf == 2)  if_req = 1'b0; end
        end
        chk("t3_mem_count", nMem, 2);
        chk("t3_if_count", nIf, 2);
        chk("t3_grant_count", grantLog.size(), 4);
        if (grantLog.size() >= 4) begin
            chk("t3_grant0", grantLog[0], 32'h40);
            chk("t3_grant1", grantLog[1], 32'h14);
            chk("t3_grant2", grantLog[2], 32'h40);
            chk("t3_grant3", grantLog[3], 32'h14);
        end
        if_req = 1'b0; mem_rd_req = 1'b0;
        step();

        // Write, then read back
        mem_addr = 32'h80; mem_wdata = 32'h12345678; mem_wr_req = 1'b1;
        memQ.push_back(expMemRdata);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) begin
                chk("t4_ram_en", {31'd0, ram_en}, 32'd1);
                chk("t4_ram_we", {31'd0, ram_we}, 32'd1);
                chk("t4_ram_addr", ram_addr, 32'h80);
                chk("t4_ram_wdata", ram_wdata, 32'h12345678);
            end
            if (c == 4) begin
                chk("t4_mem_valid", {31'd0, mem_valid}, 32'd1);
                chk("t4_mem_rdata_hold", mem_rdata, 32'hCAFEF00D);
                mem_wr_req = 1'b0;
            end
        end
        step();
        mem_rd_req = 1'b1; memQ.push_back(32'h12345678); expMemRdata = 32'h12345678;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) chk("t4_rd_we", {31'd0, ram_we}, 32'd0);
            if (c == 4) begin
                chk("t4_rd_valid", {31'd0, mem_valid}, 32'd1);
                mem_rd_req = 1'b0;
            end
        end
        step();

        // Flush during WAIT kills the fetch
        if_addr = 32'h30; if_req = 1'b1;
        step();
        step();
        flush = 1'b1; if_req = 1'b0;
        step();
        flush = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            chk($sformatf("t5_if_valid_c%0d", c), {31'd0, if_valid}, 32'd0);
            chk($sformatf("t5_if_rdata_c%0d", c), if_rdata, 32'h11112222);
            step();
        end
        if_addr = 32'h20; if_req = 1'b1; ifQ.push_back(32'h77778888);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("t5_next_valid_c%0d", c), {31'd0, if_valid}, 32'(c == 4));
        end
        if_req = 1'b0;
        step();

        // Async reset during WAIT
        if_addr = 32'h20; if_req = 1'b1;
        step();
        step();
        rstn = 1'b0; if_req = 1'b0;
        #1;
        checkAllZero("t6");
        step();
        step();
        rstn = 1'b1;
        step();
        if_addr = 32'h10; if_req = 1'b1; ifQ.push_back(32'hDEADBEEF);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!if_valid && lat < 20);
        chk("t6_latency", lat, LAT + 2);
        if_req = 1'b0;
        step();

        chk("end_ifq_empty", ifQ.size(), 0);
        chk("end_memq_empty", memQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- Shares one single-port instruction/data RAM between the fetch stage (read-only) and the memory stage (read/write).
- Sequences each access through a fixed-latency RAM port.
- Returns read data with a one-cycle valid pulse.
- Generates the per-requester stall that drives the fetch stage freeze and the memory-stage hold.
- Discards fetch results killed by a branch flush.

Parameters:
- WORD_LEN, 32, data and address width.
- MEM_LAT, 2, cycles from RAM enable sampled to ram_rdata valid; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- if_req  input  1  fetch read request; held until if_valid
- if_addr  input  WORD_LEN  fetch address (PC)
- if_rdata  output  WORD_LEN  fetched instruction
- if_valid  output  1  one-cycle pulse: if_rdata valid
- if_stall  output  1  fetch must freeze
- flush  input  1  branch taken; kill in-flight fetch result
- mem_rd_req  input  1  data read request; held until mem_valid
- mem_wr_req  input  1  data write request; held until mem_valid
- mem_addr  input  WORD_LEN  data address
- mem_wdata  input  WORD_LEN  write data
- mem_rdata  output  WORD_LEN  read data
- mem_valid  output  1  one-cycle pulse: data access complete
- mem_stall  output  1  memory stage must hold
- ram_en  output  1  RAM access strobe, one cycle per access
- ram_we  output  1  RAM write enable, qualified by ram_en
- ram_addr  output  WORD_LEN  RAM address
- ram_wdata  output  WORD_LEN  RAM write data
- ram_rdata  input  WORD_LEN  RAM read data, MEM_LAT cycles after ram_en

Behaviour:
- Reset (async, rstn=0):
  - State = IDLE, wait counter = 0, owner = none.
  - Fairness flag (if_owed) = 0.
  - All outputs 0, including the data registers.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitrate on any pending request: if_req, or mem request = mem_rd_req|mem_wr_req.
  - Latch owner, address, wdata and we; go to ISSUE.
  - No request: stay in IDLE.
- Priority:
  - MEM beats IF.
  - Exception: if if_owed=1 and if_req=1, IF wins.
  - if_owed sets when IF was pending but lost arbitration; it clears when IF is granted.
- ISSUE:
  - ram_en=1 for exactly this cycle, driven from the latched registers.
  - Load counter = MEM_LAT-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At 0, capture ram_rdata into the owner's rdata register and go to RESP.
  - With MEM_LAT=1, WAIT lasts one cycle.
- RESP:
  - Owner's valid = 1 for one cycle; go to IDLE.
  - Back-to-back requests are arbitrated in the next IDLE cycle.
- Latency: request in IDLE to valid pulse = MEM_LAT+2 cycles. One access every MEM_LAT+3 cycles maximum.
- Writes:
  - ram_we=1 with ram_en.
  - mem_valid pulses in RESP; mem_rdata is unchanged.
- If mem_rd_req and mem_wr_req are both high, treat as a write.
- Stalls (combinational):
  - if_stall = if_req & ~if_valid.
  - mem_stall = (mem_rd_req|mem_wr_req) & ~mem_valid.
- Flush:
  - flush=1 while owner=IF in ISSUE, WAIT or RESP marks the access killed.
  - The access completes on the RAM, but if_valid is suppressed and if_rdata is not updated.
  - The kill marker clears on return to IDLE.
  - flush in IDLE, or with owner=MEM, has no effect.
- A request deasserted mid-access does not abort the access; the valid pulse still occurs.
- Reset mid-access: immediate return to IDLE, ram_en=0, and the in-flight result is discarded.
- ram_addr, ram_wdata and ram_we hold their latched values outside ISSUE. They are don't-care when ram_en=0.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x10, RAM returns 0xDEADBEEF.
  - Required: ram_en in cycle 1 with ram_addr=0x10.
  - Required: if_valid in cycle 4 with if_rdata=0xDEADBEEF.
  - Required: if_stall high in cycles 0-3, low in cycle 4.
- Simultaneous requests: if_req and mem_rd_req (addr 0x40) rise together.
  - Required: MEM granted first; mem_valid at cycle 4.
  - Required: IF granted next (if_owed); if_valid at cycle 9.
- Fairness: mem_rd_req held continuously and if_req=1.
  - Required: grants alternate MEM, IF, MEM, IF; no two consecutive MEM grants while IF is pending.
- Write: mem_wr_req=1, addr 0x80, wdata 0x12345678.
  - Required: ram_en=ram_we=1 with those values in the ISSUE cycle.
  - Required: mem_valid pulse; mem_rdata unchanged.
- Flush: IF access in WAIT, flush pulsed for 1 cycle.
  - Required: no if_valid; if_rdata holds its old value.
  - Required: the next if_req after flush (addr 0x20) returns normally.
- Async reset asserted during WAIT.
  - Required: all outputs 0 immediately; after release, a new fetch completes in MEM_LAT+2 cycles.
